// File: rtl/ex6_mon_pkg.sv
// rtl/ex6_mon_pkg.sv - shared types and constants for the ex6 response monitor
package ex6_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } mon_state_t;

  // x^16 + x^12 + x^3 + x + 1
  localparam logic [15:0] DEFAULT_POLY = 16'h100B;

  // Position of each ex6 output inside y_vec
  localparam int Y1_IDX = 0;
  localparam int Y2_IDX = 1;
  localparam int Y3_IDX = 2;
  localparam int Y4_IDX = 3;
  localparam int Y5_IDX = 4;
  localparam int Y6_IDX = 5;
  localparam int Y7_IDX = 6;
  localparam int Y8_IDX = 7;

endpackage

// File: rtl/ex6_misr.sv
// rtl/ex6_misr.sv - multiple-input signature register folding an 8-bit vector per enabled cycle
module ex6_misr
  import ex6_mon_pkg::*;
#(
  parameter int               SIG_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [7:0]       din,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] r_sig;
  logic [SIG_W-1:0] w_next;

  // Galois-style shift with feedback taps, then fold in the new vector on the low bits
  assign w_next = {r_sig[SIG_W-2:0], 1'b0}
                ^ (r_sig[SIG_W-1] ? POLY : '0)
                ^ {{(SIG_W-8){1'b0}}, din};

  // Clear wins over a same-cycle sample so a restart never keeps stale data
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/ex6_resp_monitor.sv
// rtl/ex6_resp_monitor.sv - windowed signature capture, golden compare and zero-run alarm for ex6 outputs
module ex6_resp_monitor
  import ex6_mon_pkg::*;
#(
  parameter int               WINDOW       = 64,
  parameter int               SIG_W        = 16,
  parameter logic [SIG_W-1:0] POLY         = SIG_W'(DEFAULT_POLY),
  parameter int               ZERO_RUN_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_en,
  input  logic [7:0]       y_vec,
  input  logic [SIG_W-1:0] golden_sig,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] signature,
  output logic             match,
  output logic             zero_alarm
);

  localparam int CNT_W = $clog2(WINDOW + 1);
  localparam int ZR_W  = $clog2(ZERO_RUN_MAX + 1);

  mon_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [ZR_W-1:0]  r_zero_run;
  logic             r_busy;
  logic             r_done;
  logic             r_match;
  logic             r_zero_alarm;

  logic             w_clr;
  logic             w_take;
  logic             w_last;
  logic             w_y_zero;
  logic             w_sig_eq;
  logic [SIG_W-1:0] w_sig;

  // start is honoured in IDLE and CAPTURE but not in the single DONE cycle
  assign w_clr    = start && (r_state != DONE);
  assign w_take   = (r_state == CAPTURE) && sample_en && !start;
  assign w_last   = (r_cnt == CNT_W'(WINDOW - 1));
  assign w_y_zero = (y_vec == 8'h00);
  assign w_sig_eq = (w_sig == golden_sig);

  ex6_misr #(
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .clk (clk),
    .rst (rst),
    .clr (w_clr),
    .en  (w_take),
    .din (y_vec),
    .sig (w_sig)
  );

  // Window FSM with sample counter, zero-run tracking and the held compare result
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_zero_run   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_match      <= 1'b0;
      r_zero_alarm <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_clr) begin
        r_state      <= CAPTURE;
        r_busy       <= 1'b1;
        r_cnt        <= '0;
        r_zero_run   <= '0;
        r_zero_alarm <= 1'b0;
        r_match      <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          CAPTURE: begin
            if (sample_en) begin
              r_cnt <= r_cnt + CNT_W'(1);
              if (w_y_zero) begin
                if (r_zero_run != ZR_W'(ZERO_RUN_MAX)) begin
                  r_zero_run <= r_zero_run + ZR_W'(1);
                end
                if (r_zero_run == ZR_W'(ZERO_RUN_MAX - 1)) begin
                  r_zero_alarm <= 1'b1;
                end
              end else begin
                r_zero_run <= '0;
              end
              if (w_last) begin
                r_state <= DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
          DONE: begin
            r_match <= w_sig_eq;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign signature  = w_sig;
  // The final sample lands on the edge entering DONE, so the compare is live during done and held afterwards
  assign match      = (r_state == DONE) ? w_sig_eq : r_match;
  assign zero_alarm = r_zero_alarm;

endmodule

// File: tb/tb_ex6_resp_monitor.sv
// tb/tb_ex6_resp_monitor.sv - scoreboard bench for ex6_resp_monitor
module tb_ex6_resp_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_l;
  logic        sample_en;
  logic [7:0]  y_vec;
  logic [15:0] golden_sig;

  logic        busy, done, match, zero_alarm;
  logic [15:0] signature;
  logic        l_busy, l_done, l_match, l_zero_alarm;
  logic [15:0] l_signature;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] sig;
    logic        m;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  ex6_resp_monitor #(
    .WINDOW       (4),
    .SIG_W        (16),
    .POLY         (16'h100B),
    .ZERO_RUN_MAX (4)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .sample_en  (sample_en),
    .y_vec      (y_vec),
    .golden_sig (golden_sig),
    .busy       (busy),
    .done       (done),
    .signature  (signature),
    .match      (match),
    .zero_alarm (zero_alarm)
  );

  ex6_resp_monitor #(
    .WINDOW       (12),
    .SIG_W        (16),
    .POLY         (16'h100B),
    .ZERO_RUN_MAX (4)
  ) u_dut_long (
    .clk        (clk),
    .rst        (rst),
    .start      (start_l),
    .sample_en  (sample_en),
    .y_vec      (y_vec),
    .golden_sig (golden_sig),
    .busy       (l_busy),
    .done       (l_done),
    .signature  (l_signature),
    .match      (l_match),
    .zero_alarm (l_zero_alarm)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
    return {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0000) ^ {8'h00, d};
  endfunction

  task automatic push_exp(input logic [15:0] sig, input logic m);
    exp_t e;
    e.sig = sig;
    e.m   = m;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic [7:0] d);
    sample_en = 1'b1;
    y_vec     = d;
    tick();
  endtask

  task automatic pulse_start;
    sample_en = 1'b0;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Scoreboard: every done pulse must match the oldest pending expectation
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check_eq("sb_sig", {16'h0, signature}, {16'h0, mon_e.sig});
        check_eq("sb_match", {31'h0, match}, {31'h0, mon_e.m});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] t1_exp [4];
    logic [7:0]  t4_seq [8];
    logic [7:0]  t5_seq [4];
    logic [15:0] s;

    t1_exp = '{16'h0001, 16'h0003, 16'h0007, 16'h000F};
    t4_seq = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    t5_seq = '{8'h80, 8'hFF, 8'h3C, 8'h01};

    rst = 1'b0; start = 1'b0; start_l = 1'b0; sample_en = 1'b0;
    y_vec = 8'h00; golden_sig = 16'h0000;
    tick();
    tick();
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_done", {31'h0, done}, 32'd0);
    check_eq("rst_sig", {16'h0, signature}, 32'd0);
    check_eq("rst_match", {31'h0, match}, 32'd0);
    check_eq("rst_zalarm", {31'h0, zero_alarm}, 32'd0);
    rst = 1'b1;

    // T1: four samples of 0x01
    golden_sig = 16'h000F;
    push_exp(16'h000F, 1'b1);
    pulse_start();
    check_eq("t1_busy", {31'h0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      sample(8'h01);
      check_eq("t1_sig", {16'h0, signature}, {16'h0, t1_exp[i]});
      check_eq("t1_done", {31'h0, done}, (i == 3) ? 32'd1 : 32'd0);
    end
    sample_en = 1'b0;
    tick();
    check_eq("t1_done_clr", {31'h0, done}, 32'd0);
    check_eq("t1_busy_clr", {31'h0, busy}, 32'd0);
    check_eq("t1_match_hold", {31'h0, match}, 32'd1);
    check_eq("t1_sig_hold", {16'h0, signature}, 32'h000F);

    // T2: sample_en low on alternate cycles
    push_exp(16'h000F, 1'b1);
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      sample_en = (i % 2 == 1);
      y_vec     = 8'h01;
      tick();
      check_eq("t2_done", {31'h0, done}, (i == 7) ? 32'd1 : 32'd0);
    end
    sample_en = 1'b0;
    tick();

    // T3: four zero samples raise the sticky alarm
    golden_sig = 16'h0000;
    push_exp(16'h0000, 1'b1);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      sample(8'h00);
      check_eq("t3_zalarm", {31'h0, zero_alarm}, (i == 3) ? 32'd1 : 32'd0);
    end
    sample(8'h0D);
    check_eq("t3_zalarm_sticky", {31'h0, zero_alarm}, 32'd1);
    sample_en = 1'b0;
    tick();
    check_eq("t3_zalarm_sticky2", {31'h0, zero_alarm}, 32'd1);

    // T4: zero run of 3, a nonzero, then zeros; long window sees the full sequence
    golden_sig = 16'h0001;
    push_exp(16'h0001, 1'b1);
    sample_en = 1'b0;
    start = 1'b1; start_l = 1'b1;
    tick();
    start = 1'b0; start_l = 1'b0;
    check_eq("t4_zalarm_clr", {31'h0, zero_alarm}, 32'd0);
    check_eq("t4_match_clr", {31'h0, match}, 32'd0);
    check_eq("t4_l_zalarm_clr", {31'h0, l_zero_alarm}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      sample(t4_seq[i]);
      check_eq("t4_zalarm", {31'h0, zero_alarm}, 32'd0);
      check_eq("t4_l_zalarm", {31'h0, l_zero_alarm}, (i == 7) ? 32'd1 : 32'd0);
    end

    // Long window: twelve 0xFF samples exercise the feedback taps
    sample_en = 1'b0;
    start_l = 1'b1;
    tick();
    start_l = 1'b0;
    check_eq("fb_l_zalarm_clr", {31'h0, l_zero_alarm}, 32'd0);
    s = 16'h0000;
    for (int i = 0; i < 12; i++) begin
      sample(8'hFF);
      s = misr_step(s, 8'hFF);
      check_eq("fb_l_done", {31'h0, l_done}, (i == 11) ? 32'd1 : 32'd0);
    end
    check_eq("fb_l_sig", {16'h0, l_signature}, {16'h0, s});
    sample_en = 1'b0;
    tick();

    // T5: restart on the third sample of a window
    golden_sig = 16'h1234;
    pulse_start();
    sample(8'h11);
    sample(8'h22);
    start = 1'b1;
    sample(8'h33);
    start = 1'b0;
    check_eq("t5_sig_clr", {16'h0, signature}, 32'd0);
    check_eq("t5_busy", {31'h0, busy}, 32'd1);
    check_eq("t5_done", {31'h0, done}, 32'd0);
    s = 16'h0000;
    for (int i = 0; i < 4; i++) s = misr_step(s, t5_seq[i]);
    push_exp(s, s == 16'h1234);
    for (int i = 0; i < 4; i++) begin
      sample(t5_seq[i]);
      check_eq("t5_done_new", {31'h0, done}, (i == 3) ? 32'd1 : 32'd0);
    end
    sample_en = 1'b0;
    tick();

    // T6: reset in the middle of a window
    golden_sig = 16'h000F;
    pulse_start();
    sample(8'h55);
    sample(8'h66);
    check_eq("t6_busy_pre", {31'h0, busy}, 32'd1);
    rst = 1'b0;
    sample_en = 1'b0;
    tick();
    check_eq("t6_busy", {31'h0, busy}, 32'd0);
    check_eq("t6_done", {31'h0, done}, 32'd0);
    check_eq("t6_sig", {16'h0, signature}, 32'd0);
    check_eq("t6_match", {31'h0, match}, 32'd0);
    check_eq("t6_zalarm", {31'h0, zero_alarm}, 32'd0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) sample(8'h01);
    check_eq("t6_idle_done", {31'h0, done}, 32'd0);
    check_eq("t6_idle_sig", {16'h0, signature}, 32'd0);
    push_exp(16'h000F, 1'b1);
    pulse_start();
    for (int i = 0; i < 4; i++) sample(8'h01);
    check_eq("t6_done_after", {31'h0, done}, 32'd1);
    sample_en = 1'b0;
    tick();
    tick();

    check_eq("sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
